muldiv_unit: RTL

- Iterative 64-bit multiply/divide execution unit; sits directly downstream of the processor register file.
- Consumes two operands read from the register file plus a destination register index.
- Produces a result and destination index that drive one register-file write port (write_port/write_data/write).
- Fixed-latency radix-2 engine (one bit per cycle) with valid/ready handshakes on both sides.

---
 rtl/muldiv_unit.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit feeding one register-file write port.
// One bit per cycle for XLEN cycles; result held until the consumer takes it.
module muldiv_unit #(
   parameter int XLEN    = 64,
   parameter int RADDR_W = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [1:0]         in_op,
   input  logic [XLEN-1:0]    in_a,
   input  logic [XLEN-1:0]    in_b,
   input  logic [RADDR_W-1:0] in_rd,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [RADDR_W-1:0] out_rd,
   output logic [XLEN-1:0]    out_data
);

   localparam int CNT_W = $clog2(XLEN + 1);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t             state_q, state_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic [RADDR_W-1:0] rd_q, rd_d;
   logic [RADDR_W-1:0] out_rd_q, out_rd_d;
   logic [XLEN-1:0]    out_data_q, out_data_d;
   logic [1:0]         op_q, op_d;
   logic [XLEN-1:0]    opnd_q, opnd_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*XLEN-1:0]  acc_q, acc_d;

   // Ops 01/10 divide, 00/11 multiply; op[1] selects the upper accumulator half.
   logic              is_div_q, in_is_div;
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_shift;
   logic [XLEN:0]     div_diff;
   logic              div_ge;
   logic              div_unused;
   logic [2*XLEN-1:0] mul_next, div_next, acc_step;

   assign is_div_q  = op_q[0] ^ op_q[1];
   assign in_is_div = in_op[0] ^ in_op[1];

   // Multiply: {product_hi, multiplier} shifts right, adding the multiplicand on bit 0.
   assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                     {1'b0, (acc_q[0] ? opnd_q : {XLEN{1'b0}})};
   assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

   // Divide: {remainder, dividend/quotient} shifts left; restore when the trial goes negative.
   assign div_shift  = acc_q[2*XLEN-1:XLEN-1];
   assign div_diff   = div_shift - {1'b0, opnd_q};
   assign div_ge     = (div_shift >= {1'b0, opnd_q});
   assign div_unused = div_diff[XLEN];
   assign div_next   = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                        acc_q[XLEN-2:0], div_ge};

   assign acc_step = is_div_q ? div_next : mul_next;

   always_comb begin
      state_d     = state_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      rd_d        = rd_q;
      out_rd_d    = out_rd_q;
      out_data_d  = out_data_q;
      op_d        = op_q;
      opnd_d      = opnd_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready_q) begin
               op_d       = in_op;
               rd_d       = in_rd;
               opnd_d     = in_is_div ? in_b : in_a;
               acc_d      = {{XLEN{1'b0}}, (in_is_div ? in_a : in_b)};
               cnt_d      = '0;
               in_ready_d = 1'b0;
               state_d    = S_BUSY;
            end
         end
         S_BUSY: begin
            acc_d = acc_step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ITER) begin
               out_valid_d = 1'b1;
               out_rd_d    = rd_q;
               out_data_d  = op_q[1] ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0];
               state_d     = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         rd_q        <= '0;
         out_rd_q    <= '0;
         out_data_q  <= '0;
         op_q        <= '0;
         opnd_q      <= '0;
         cnt_q       <= '0;
         acc_q       <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         rd_q        <= rd_d;
         out_rd_q    <= out_rd_d;
         out_data_q  <= out_data_d;
         op_q        <= op_d;
         opnd_q      <= opnd_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_rd    = out_rd_q;
   assign out_data  = out_data_q;

endmodule
